// File: rtl/rst_seq_if.sv
// rst_seq_if: request/status bundle of the reset sequencer.
// master raises requests and watches resets; slave is rst_seq.
interface rst_seq_if;
  logic       ram_rdy;
  logic       sw_rst_req;
  logic       wdg_kick;
  logic       rst_mem;
  logic       rst_io;
  logic       rst_cpu;
  logic       seq_done;
  logic       mem_fail;
  logic [1:0] rst_cause;

  modport master (
    output ram_rdy, sw_rst_req, wdg_kick,
    input  rst_mem, rst_io, rst_cpu,
    input  seq_done, mem_fail, rst_cause
  );

  modport slave (
    input  ram_rdy, sw_rst_req, wdg_kick,
    output rst_mem, rst_io, rst_cpu,
    output seq_done, mem_fail, rst_cause
  );
endinterface

// File: rtl/rst_seq.sv
// rst_seq: staged mem -> io -> cpu reset release sequencer.
// Define RST_SEQ_WDOG_EN to build in the RUN-state watchdog.
module rst_seq #(
  parameter int MEM_TMO  = 1000,
  parameter int IO_DLY   = 8,
  parameter int SW_PULSE = 16,
  parameter int WDG_CYC  = 1048576
) (
  input  logic     clk,
  input  logic     rst,
  rst_seq_if.slave bus
);

  localparam int MRST_LEN = 4;
  localparam int MAX_A =
    (MEM_TMO > IO_DLY) ? MEM_TMO : IO_DLY;
  localparam int MAX_B =
    (SW_PULSE > MRST_LEN) ? SW_PULSE : MRST_LEN;
  localparam int MAX_P =
    (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    HOLD, MEM, MRST, IO, RUN, PULSE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    tries;
  logic [1:0]    tries_nx;
  logic          fail;
  logic          fail_nx;
  logic [1:0]    cause;
  logic [1:0]    cause_nx;
  logic          rst_mem_q;
  logic          rst_io_q;
  logic          rst_cpu_q;
  logic          done_q;
  logic          wdg_fire;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

`ifdef RST_SEQ_WDOG_EN
  localparam int WW = $clog2(WDG_CYC);

  logic [WW-1:0] wcnt;

  // a kick in the expiry cycle restarts the period
  assign wdg_fire = (state == RUN) && !bus.wdg_kick &&
                    (wcnt == WW'(WDG_CYC - 1));

  // cycles in RUN since entry or the last kick
  always_ff @(posedge clk) begin
    if (rst || state != RUN || bus.wdg_kick)
      wcnt <= '0;
    else if (wcnt != '1)
      wcnt <= wcnt + WW'(1);
  end
`else
  logic unused_wdg;

  assign unused_wdg = bus.wdg_kick ^ (WDG_CYC == 0);
  assign wdg_fire   = 1'b0;
`endif

  // next state, phase counter, attempts and cause
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_inc;
    tries_nx = tries;
    fail_nx  = fail;
    cause_nx = cause;
    unique case (state)
      HOLD: begin
        state_nx = MEM;
        cnt_nx   = '0;
      end
      MEM: begin
        if (bus.ram_rdy) begin
          state_nx = IO;
          cnt_nx   = '0;
        end else if (cnt == CW'(MEM_TMO - 1)) begin
          cnt_nx = '0;
          if (tries != 2'd3) begin
            state_nx = MRST;
            tries_nx = tries + 2'd1;
          end else begin
            state_nx = IO;
            fail_nx  = 1'b1;
          end
        end
      end
      MRST: begin
        if (cnt == CW'(MRST_LEN - 1)) begin
          state_nx = MEM;
          cnt_nx   = '0;
        end
      end
      IO: begin
        if (cnt == CW'(IO_DLY - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        cnt_nx = '0;
        if (wdg_fire) begin
          state_nx = PULSE;
          cause_nx = 2'b10;
        end else if (bus.sw_rst_req) begin
          state_nx = PULSE;
          cause_nx = 2'b01;
        end
      end
      PULSE: begin
        if (cnt == CW'(SW_PULSE - 1)) begin
          state_nx = IO;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = HOLD;
        cnt_nx   = '0;
      end
    endcase
  end

  // state and registered reset outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      tries     <= '0;
      fail      <= 1'b0;
      cause     <= 2'b00;
      rst_mem_q <= 1'b1;
      rst_io_q  <= 1'b1;
      rst_cpu_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      tries     <= tries_nx;
      fail      <= fail_nx;
      cause     <= cause_nx;
      rst_mem_q <= (state_nx == HOLD) ||
                   (state_nx == MRST);
      rst_io_q  <= (state_nx != IO) &&
                   (state_nx != RUN);
      rst_cpu_q <= (state_nx != RUN);
      done_q    <= (state_nx == RUN);
    end
  end

  assign bus.rst_mem   = rst_mem_q;
  assign bus.rst_io    = rst_io_q;
  assign bus.rst_cpu   = rst_cpu_q;
  assign bus.seq_done  = done_q;
  assign bus.mem_fail  = fail;
  assign bus.rst_cause = cause;

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter MEM_TMO, default 1000: cycles to wait for ram_rdy per attempt (range 2..65535).
REQ-002 SHALL have parameter IO_DLY, default 8: cycles between I/O release and CPU release (range 1..255).
REQ-003 SHALL have parameter SW_PULSE, default 16: length in cycles of a software/watchdog reset pulse (range 1..255).
REQ-004 SHALL have parameter WDG_CYC, default 1048576: watchdog period in cycles (range 2..2^24).
REQ-005 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 ram_rdy  input  1  memory controller initialisation complete; level signal.
REQ-008 sw_rst_req  input  1  software reset request; single-cycle pulse.
REQ-009 wdg_kick  input  1  watchdog restart; single-cycle pulse.
REQ-010 rst_mem  output  1  memory controller reset, active-high.
REQ-011 rst_io  output  1  I/O device reset, active-high.
REQ-012 rst_cpu  output  1  CPU reset, active-high.
REQ-013 seq_done  output  1  high while in RUN.
REQ-014 mem_fail  output  1  sticky: memory did not become ready after all attempts.
REQ-015 rst_cause  output  2  cause of last release: 00 power-on, 01 software, 10 watchdog.

Function
REQ-016 SHALL implement states HOLD, MEM, MRST, IO, RUN, PULSE; all outputs SHALL be registered.
REQ-017 HOLD: rst_mem=rst_io=rst_cpu=1, seq_done=0; first edge with rst=0 -> MEM, rst_mem=0.
REQ-018 MEM: cycle counter counts from 0; ram_rdy=1 sampled -> IO on next edge, rst_io=0, counter cleared.
REQ-019 MEM: counter reaching MEM_TMO-1 with ram_rdy=0 -> MRST if attempts<3, else set mem_fail=1 and -> IO.
REQ-020 MRST: rst_mem=1 for exactly 4 cycles, attempt count +1, then -> MEM with counter cleared.
REQ-021 IO: after exactly IO_DLY cycles -> RUN; rst_cpu=0 and seq_done=1 on the same edge.
REQ-022 RUN: sw_rst_req=1 -> PULSE, rst_io=rst_cpu=1, seq_done=0, rst_cause=01; rst_mem stays 0.
REQ-023 PULSE: after exactly SW_PULSE cycles -> IO (memory not re-initialised).
REQ-024 sw_rst_req outside RUN SHALL be ignored; it is not queued.
REQ-025 Watchdog expiry and sw_rst_req in the same cycle: watchdog wins, rst_cause=10.
REQ-026 ram_rdy dropping after MEM left SHALL be ignored.
REQ-027 Counters SHALL saturate and never wrap; counter width sized from the largest parameter.

Reset
REQ-028 rst=1 SHALL, from any state and mid-sequence, force HOLD on the next edge: rst_mem=rst_io=rst_cpu=1, seq_done=0, mem_fail=0, rst_cause=00, attempts=0, all counters 0.
REQ-029 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-030 Macro RST_SEQ_WDOG_EN defined: in RUN, a counter counts cycles since entering RUN or last wdg_kick; reaching WDG_CYC-1 -> PULSE with rst_cause=10; counter cleared on wdg_kick and outside RUN.
REQ-031 RST_SEQ_WDOG_EN undefined: no watchdog logic; wdg_kick SHALL be ignored and rst_cause never 10.

Verification
REQ-032 rst 1->0, ram_rdy=1 after 5 cycles in MEM, IO_DLY=8 -> rst_mem low at edge 1, rst_io low at edge 7, rst_cpu and seq_done at edge 15, rst_cause=00.
REQ-033 ram_rdy held 0, MEM_TMO=10 -> three MEM/MRST rounds (10+4 cycles each), fourth timeout sets mem_fail=1, sequence then completes through IO.
REQ-034 In RUN, sw_rst_req pulse, SW_PULSE=16 -> rst_io/rst_cpu high 16 cycles, rst_mem stays 0, re-release after 8 more cycles, rst_cause=01.
REQ-035 rst asserted in IO cycle 3 -> next edge all resets high, mem_fail=0, seq_done=0; full sequence repeats on release.
REQ-036 RST_SEQ_WDOG_EN defined, WDG_CYC=100: kicks every 50 cycles -> no reset; kicks stopped -> PULSE entered 100 cycles after last kick, rst_cause=10.
REQ-037 RST_SEQ_WDOG_EN defined, expiry coincident with sw_rst_req -> rst_cause=10; undefined build, no kicks for 10^6 cycles -> stays in RUN.
